// File: rtl/rx_unit.sv
// UART receiver: 8N1 frames recovered by bit-period counting and mid-bit sampling, with a hold-until-read handshake.
// Define RX_PARITY_EN to receive 8E1 frames and drive o_parity_error.
module rx_unit #(
    parameter int RX_DATA_SIZE  = 8,
    parameter int TICKS_PER_BIT = 868
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_rx,
    input  logic                    i_read,
    output logic [RX_DATA_SIZE-1:0] o_rxdata,
    output logic                    o_valid,
    output logic                    o_frame_error,
    output logic                    o_overrun,
    output logic                    o_parity_error
);

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = $clog2(TICKS_PER_BIT);
    localparam int BIT_W       = $clog2(RX_DATA_SIZE + 1);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(TICKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(RX_DATA_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                  state_reg, state_next;
    logic [SYNC_STAGES-1:0]  sync_reg;
    logic                    rx_prev_reg;
    logic [CNT_W-1:0]        tick_reg, tick_next;
    logic [BIT_W-1:0]        bit_reg, bit_next;
    logic [RX_DATA_SIZE-1:0] shift_reg, shift_next;
    logic [RX_DATA_SIZE-1:0] rxdata_reg, rxdata_next;
    logic                    valid_reg, valid_next;
    logic                    frame_err_reg, frame_err_next;
    logic                    overrun_reg, overrun_next;
    logic                    rx_s;
    logic                    fall_edge;
    logic                    parity_ok;

    // Synchronizer chain idles high so reset never looks like a start edge.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clock) begin
                    if (i_reset) sync_reg[gi] <= 1'b1;
                    else         sync_reg[gi] <= i_rx;
                end
            end else begin : g_chain
                always_ff @(posedge i_clock) begin
                    if (i_reset) sync_reg[gi] <= 1'b1;
                    else         sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_s      = sync_reg[SYNC_STAGES-1];
    assign fall_edge = rx_prev_reg & ~rx_s;

`ifdef RX_PARITY_EN
    logic parity_bit_reg, parity_bit_next;
    logic parity_err_reg, parity_err_next;

    assign parity_ok      = (parity_bit_reg == ^shift_reg);
    assign o_parity_error = parity_err_reg;
`else
    assign parity_ok      = 1'b1;
    assign o_parity_error = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg      <= ST_IDLE;
            rx_prev_reg    <= 1'b1;
            tick_reg       <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            rxdata_reg     <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            rx_prev_reg    <= rx_s;
            tick_reg       <= tick_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            rxdata_reg     <= rxdata_next;
            valid_reg      <= valid_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
`ifdef RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        tick_next       = tick_reg;
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        rxdata_next     = rxdata_reg;
        valid_next      = valid_reg & ~i_read;
        frame_err_next  = 1'b0;
        overrun_next    = 1'b0;
`ifdef RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (fall_edge) begin
                    tick_next  = '0;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (tick_reg == HALF_LAST) begin
                    tick_next = '0;
                    bit_next  = '0;
                    // A line back high at mid start bit was noise, not a frame.
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end

            ST_DATA: begin
                if (tick_reg == TICK_LAST) begin
                    tick_next  = '0;
                    shift_next = {rx_s, shift_reg[RX_DATA_SIZE-1:1]};
                    if (bit_reg == DATA_LAST) begin
`ifdef RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end

`ifdef RX_PARITY_EN
            ST_PARITY: begin
                if (tick_reg == TICK_LAST) begin
                    tick_next       = '0;
                    parity_bit_next = rx_s;
                    state_next      = ST_STOP;
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (tick_reg == TICK_LAST) begin
                    tick_next      = '0;
                    state_next     = ST_IDLE;
                    frame_err_next = ~rx_s;
`ifdef RX_PARITY_EN
                    parity_err_next = ~parity_ok;
`endif
                    if (rx_s && parity_ok) begin
                        // A read in the same cycle frees the slot, so that is not an overrun.
                        rxdata_next  = shift_reg;
                        valid_next   = 1'b1;
                        overrun_next = valid_reg & ~i_read;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign o_rxdata      = rxdata_reg;
    assign o_valid       = valid_reg;
    assign o_frame_error = frame_err_reg;
    assign o_overrun     = overrun_reg;

endmodule

// File: tb/tb_rx_unit.sv
// Bench for rx_unit at 16 ticks per bit: serial frames are driven, good bytes queued,
// and each byte the receiver presents is popped and compared.
module tb_rx_unit;

    localparam int T = 16;
`ifdef RX_PARITY_EN
    localparam int LAT = 2 + T/2 + 10*T + 1;
`else
    localparam int LAT = 2 + T/2 + 9*T + 1;
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rd;
    logic [7:0] o_rxdata;
    logic       o_valid;
    logic       o_frame_error;
    logic       o_overrun;
    logic       o_parity_error;

    int checks;
    int errors;
    int cyc;
    int fall_cyc;
    int rise_cyc;
    int ferr_cnt;
    int ovr_cnt;
    int perr_cnt;
    int deliv_cnt;
    int push_cnt;
    logic [7:0] sb_q[$];

    rx_unit #(
        .RX_DATA_SIZE (8),
        .TICKS_PER_BIT(T)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_rx          (rx),
        .i_read        (rd),
        .o_rxdata      (o_rxdata),
        .o_valid       (o_valid),
        .o_frame_error (o_frame_error),
        .o_overrun     (o_overrun),
        .o_parity_error(o_parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic par_of(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read();
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
    endtask

    // Drives start, data LSB first, optional parity, then stop; leaves the line at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par, input bit push);
        bit good;
`ifdef RX_PARITY_EN
        good = push && stop_bit && (par == par_of(d));
`else
        good = push && stop_bit && (par == par || 1'b1);
`endif
        if (good) begin
            sb_q.push_back(d);
            push_cnt++;
        end
        $display("tx frame 0x%02h stop=%0b par=%0b expect_byte=%0b at cycle %0d", d, stop_bit, par, good, cyc);
        fall_cyc = cyc;
        rx = 1'b0;
        wait_cyc(T);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(T);
        end
`ifdef RX_PARITY_EN
        rx = par;
        wait_cyc(T);
`endif
        rx = stop_bit;
        wait_cyc(T);
    endtask

    // Monitor: a byte is presented when valid rises, or the held byte is replaced while valid.
    initial begin
        logic       prev_valid;
        logic [7:0] prev_data;
        logic [8:0] exp;
        prev_valid = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (o_frame_error)  ferr_cnt++;
            if (o_overrun)      ovr_cnt++;
            if (o_parity_error) perr_cnt++;
            if (o_valid && (!prev_valid || o_rxdata != prev_data || o_overrun)) begin
                if (!prev_valid) rise_cyc = cyc;
                deliv_cnt++;
                if (sb_q.size() != 0) exp = {1'b0, sb_q.pop_front()};
                else                  exp = 9'h100;
                $display("rx byte 0x%02h overrun=%0b at cycle %0d", o_rxdata, o_overrun, cyc);
                check_eq("sb_byte", {1'b0, o_rxdata}, exp);
            end
            prev_valid = o_valid;
            prev_data  = o_rxdata;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_out;
        int   base;
        checks = 0; errors = 0;
        ferr_cnt = 0; ovr_cnt = 0; perr_cnt = 0; deliv_cnt = 0; push_cnt = 0;
        fall_cyc = 0; rise_cyc = 0;
        rst = 1'b1; rx = 1'b1; rd = 1'b0;

        wait_cyc(5);
        @(negedge clk);
        check_eq("rst_rxdata", o_rxdata, 0);
        check_eq("rst_valid", o_valid, 0);
        wait_cyc(1);
        rst = 1'b0;

        any_out = 1'b0;
        repeat (100) begin
            @(negedge clk);
            any_out = any_out | o_valid | o_frame_error | o_overrun | o_parity_error | (|o_rxdata);
        end
        check_eq("idle_quiet", any_out, 0);
        wait_cyc(1);

        // First byte: exact latency and handshake
        send_frame(8'hA5, 1'b1, par_of(8'hA5), 1);
        wait_cyc(4);
        check_eq("a5_latency", rise_cyc - fall_cyc, LAT);
        check_eq("a5_valid", o_valid, 1);
        do_read();
        check_eq("a5_read_valid", o_valid, 0);
        check_eq("a5_hold_data", o_rxdata, 8'hA5);

        // Glitch shorter than half a bit
        rx = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        wait_cyc(40);
        check_eq("glitch_valid", o_valid, 0);
        check_eq("glitch_ferr", ferr_cnt, 0);
        send_frame(8'h3C, 1'b1, par_of(8'h3C), 1);
        wait_cyc(4);
        check_eq("3c_valid", o_valid, 1);
        do_read();

        // Stop bit low, then break
        base = ferr_cnt;
        send_frame(8'h55, 1'b0, par_of(8'h55), 1);
        wait_cyc(500);
        check_eq("ferr_pulse", ferr_cnt - base, 1);
        check_eq("ferr_valid", o_valid, 0);
        rx = 1'b1;
        wait_cyc(40);
        check_eq("break_no_retrigger", ferr_cnt - base, 1);
        check_eq("break_valid", o_valid, 0);

        // Back to back, never read: overrun
        base = ovr_cnt;
        send_frame(8'h01, 1'b1, par_of(8'h01), 1);
        send_frame(8'h02, 1'b1, par_of(8'h02), 1);
        wait_cyc(4);
        check_eq("ovr_valid", o_valid, 1);
        check_eq("ovr_data", o_rxdata, 8'h02);
        check_eq("ovr_pulse", ovr_cnt - base, 1);
        do_read();
        wait_cyc(2);

        // Back to back with read on the arrival cycle: no overrun
        base = ovr_cnt;
        send_frame(8'h01, 1'b1, par_of(8'h01), 1);
        fork
            send_frame(8'h02, 1'b1, par_of(8'h02), 1);
            begin
                wait_cyc(LAT - 1);
                rd = 1'b1;
                wait_cyc(1);
                rd = 1'b0;
            end
        join
        wait_cyc(4);
        check_eq("rdsim_valid", o_valid, 1);
        check_eq("rdsim_data", o_rxdata, 8'h02);
        check_eq("rdsim_no_ovr", ovr_cnt - base, 0);
        do_read();
        wait_cyc(2);

        // Reset during data bit 4 of 0xFF (parity bit kept high so the line stays idle)
        base = deliv_cnt;
        fork
            send_frame(8'hFF, 1'b1, 1'b1, 0);
            begin
                wait_cyc(5*T + 5);
                rst = 1'b1;
                wait_cyc(2);
                rst = 1'b0;
            end
        join
        wait_cyc(10);
        check_eq("rstmid_valid", o_valid, 0);
        check_eq("rstmid_no_byte", deliv_cnt - base, 0);
        send_frame(8'h81, 1'b1, par_of(8'h81), 1);
        wait_cyc(4);
        check_eq("81_valid", o_valid, 1);
        check_eq("81_data", o_rxdata, 8'h81);
        do_read();

`ifdef RX_PARITY_EN
        base = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1);
        wait_cyc(4);
        check_eq("par_ok_valid", o_valid, 1);
        check_eq("par_ok_no_err", perr_cnt - base, 0);
        do_read();
        send_frame(8'h07, 1'b1, 1'b0, 1);
        wait_cyc(4);
        check_eq("par_bad_pulse", perr_cnt - base, 1);
        check_eq("par_bad_valid", o_valid, 0);
`else
        check_eq("no_parity_err", perr_cnt, 0);
`endif

        wait_cyc(20);
        check_eq("sb_drained", sb_q.size(), 0);
        check_eq("deliv_count", deliv_cnt, push_cnt);
        check_eq("total_ferr", ferr_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
